// File: rtl/mc_ctrl_pkg.sv
// Shared constants for the multicycle main controller: state encoding,
// next-PC selects, datapath control encodings, opcode/funct values and
// the bit positions of the one-hot instruction class vector.
// Optional feature macro: CTRL_INT_EN (interrupt entry, INT state, eret).
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXE,
        S_ADR,
        S_MRD,
        S_MWR,
        S_WB,
        S_BR,
        S_JMP
`ifdef CTRL_INT_EN
        , S_INT
`endif
    } state_t;

    // Next-PC select encodings
    localparam logic [2:0] NPC_ADD4    = 3'd0;
    localparam logic [2:0] NPC_REG_JMP = 3'd1;
    localparam logic [2:0] NPC_J_JMP   = 3'd2;
    localparam logic [2:0] NPC_BEQ_JMP = 3'd3;
`ifdef CTRL_INT_EN
    localparam logic [2:0] NPC_INT_JMP = 3'd4;
`endif

    // ALU operation encodings
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_OR  = 3'd2;
    localparam logic [2:0] ALU_LUI = 3'd3;

    // Destination register select
    localparam logic [1:0] REGDST_RT = 2'd0;
    localparam logic [1:0] REGDST_RD = 2'd1;
    localparam logic [1:0] REGDST_31 = 2'd2;

    // Register write data select
    localparam logic [1:0] WD_ALU = 2'd0;
    localparam logic [1:0] WD_MEM = 2'd1;
    localparam logic [1:0] WD_PC  = 2'd2;

    // Immediate extension
    localparam logic [1:0] EXT_ZERO = 2'd0;
    localparam logic [1:0] EXT_SIGN = 2'd1;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    // R-type funct values
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_JR   = 6'b001000;

`ifdef CTRL_INT_EN
    localparam logic [5:0] OP_COP0 = 6'b010000;
    localparam logic [5:0] FN_ERET = 6'b011000;
`endif

    // One-hot instruction class bit positions; all-zero means NOP
    localparam int CLS_ADDU = 0;
    localparam int CLS_SUBU = 1;
    localparam int CLS_JR   = 2;
    localparam int CLS_ORI  = 3;
    localparam int CLS_LUI  = 4;
    localparam int CLS_LW   = 5;
    localparam int CLS_SW   = 6;
    localparam int CLS_BEQ  = 7;
    localparam int CLS_J    = 8;
    localparam int CLS_JAL  = 9;
    localparam int CLS_ERET = 10;
    localparam int CLS_W    = 11;

endpackage

// File: rtl/mc_ctrl_if.sv
// Control bus between the main controller and the datapath/fetch unit.
// Optional feature macro: CTRL_INT_EN adds the CP0 request and controls.
interface mc_ctrl_if;
    logic [31:0] instruction;
    logic        Zero;
    logic        IRWr;
    logic        PCWr;
    logic [2:0]  NPCSel;
    logic        RegWr;
    logic [1:0]  RegDst;
    logic [1:0]  WDSel;
    logic        ALUSrc;
    logic [2:0]  ALUOp;
    logic [1:0]  ExtOp;
    logic        MemWr;
`ifdef CTRL_INT_EN
    logic        IntReq;
    logic        EPCWr;
    logic        EXLSet;
    logic        EXLClr;
    logic        EPCToPC;
`endif

    modport master (
        input  instruction, Zero,
`ifdef CTRL_INT_EN
        input  IntReq,
        output EPCWr, EXLSet, EXLClr, EPCToPC,
`endif
        output IRWr, PCWr, NPCSel, RegWr, RegDst, WDSel,
        output ALUSrc, ALUOp, ExtOp, MemWr
    );

    modport slave (
        output instruction, Zero,
`ifdef CTRL_INT_EN
        output IntReq,
        input  EPCWr, EXLSet, EXLClr, EPCToPC,
`endif
        input  IRWr, PCWr, NPCSel, RegWr, RegDst, WDSel,
        input  ALUSrc, ALUOp, ExtOp, MemWr
    );
endinterface

// File: rtl/mc_ctrl_instr_decode.sv
// Combinational decode of the stored instruction word into a one-hot
// class vector. Unrecognised opcode/funct yields all zeros (NOP).
// Optional feature macro: CTRL_INT_EN enables the eret decode.
module instr_decode
    import mc_ctrl_pkg::*;
(
    input  logic [31:0]      instr,
    output logic [CLS_W-1:0] cls
);
    logic [5:0] op;
    logic [5:0] funct;
    logic       unused_fields;

    assign op            = instr[31:26];
    assign funct         = instr[5:0];
    assign unused_fields = ^instr[25:6];

    // Opcode/funct lookup; defaults to NOP
    always_comb begin
        cls = '0;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU: cls[CLS_ADDU] = 1'b1;
                    FN_SUBU: cls[CLS_SUBU] = 1'b1;
                    FN_JR:   cls[CLS_JR]   = 1'b1;
                    default: cls = '0;
                endcase
            end
            OP_ORI: cls[CLS_ORI] = 1'b1;
            OP_LUI: cls[CLS_LUI] = 1'b1;
            OP_LW:  cls[CLS_LW]  = 1'b1;
            OP_SW:  cls[CLS_SW]  = 1'b1;
            OP_BEQ: cls[CLS_BEQ] = 1'b1;
            OP_J:   cls[CLS_J]   = 1'b1;
            OP_JAL: cls[CLS_JAL] = 1'b1;
`ifdef CTRL_INT_EN
            OP_COP0: if (instr[25] && funct == FN_ERET) cls[CLS_ERET] = 1'b1;
`endif
            default: cls = '0;
        endcase
    end
endmodule

// File: rtl/mc_ctrl.sv
// Multicycle main controller: state register, stored instruction copy
// and Moore-style output decode (BR PCWr follows Zero combinationally).
// Optional feature macro: CTRL_INT_EN adds interrupt entry and eret.
module mc_ctrl
    import mc_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    mc_ctrl_if.master     bus
);
    state_t           state_q, state_d;
    logic [31:0]      ir_q;
    logic [CLS_W-1:0] cls;
    state_t           term_next;

    logic       ir_wr, pc_wr, reg_wr, alu_src, mem_wr;
    logic [2:0] npc_sel, alu_op;
    logic [1:0] reg_dst, wd_sel, ext_op;
`ifdef CTRL_INT_EN
    logic       epc_wr, exl_set, exl_clr, epc_to_pc;
`endif

    instr_decode u_decode (
        .instr (ir_q),
        .cls   (cls)
    );

`ifdef CTRL_INT_EN
    assign term_next = bus.IntReq ? S_INT : S_FETCH;
`else
    assign term_next = S_FETCH;
`endif

    // State register; reset aborts any instruction in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // StoredInstruction: captured from the fetch unit at the end of FETCH
    always_ff @(posedge clk or posedge reset) begin
        if (reset)      ir_q <= '0;
        else if (ir_wr) ir_q <= bus.instruction;
    end

    // Next-state and control decode; every output defaults to 0
    always_comb begin
        state_d = state_q;
        ir_wr   = 1'b0;
        pc_wr   = 1'b0;
        npc_sel = NPC_ADD4;
        reg_wr  = 1'b0;
        reg_dst = REGDST_RT;
        wd_sel  = WD_ALU;
        alu_src = 1'b0;
        alu_op  = ALU_ADD;
        ext_op  = EXT_ZERO;
        mem_wr  = 1'b0;
`ifdef CTRL_INT_EN
        epc_wr    = 1'b0;
        exl_set   = 1'b0;
        exl_clr   = 1'b0;
        epc_to_pc = 1'b0;
`endif
        case (state_q)
            S_FETCH: begin
                ir_wr   = 1'b1;
                pc_wr   = 1'b1;
                npc_sel = NPC_ADD4;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (cls[CLS_ADDU] | cls[CLS_SUBU] | cls[CLS_ORI] | cls[CLS_LUI])
                    state_d = S_EXE;
                else if (cls[CLS_LW] | cls[CLS_SW])
                    state_d = S_ADR;
                else if (cls[CLS_BEQ])
                    state_d = S_BR;
                else if (cls[CLS_J] | cls[CLS_JAL] | cls[CLS_JR] | cls[CLS_ERET])
                    state_d = S_JMP;
                else
                    state_d = term_next;
            end
            S_EXE: begin
                ext_op = EXT_SIGN;
                if (cls[CLS_ORI]) begin
                    alu_src = 1'b1;
                    alu_op  = ALU_OR;
                    ext_op  = EXT_ZERO;
                end else if (cls[CLS_LUI]) begin
                    alu_src = 1'b1;
                    alu_op  = ALU_LUI;
                end else if (cls[CLS_SUBU]) begin
                    alu_op  = ALU_SUB;
                end
                state_d = S_WB;
            end
            S_ADR: begin
                alu_src = 1'b1;
                ext_op  = EXT_SIGN;
                alu_op  = ALU_ADD;
                state_d = cls[CLS_LW] ? S_MRD : S_MWR;
            end
            S_MRD: begin
                wd_sel  = WD_MEM;
                reg_dst = REGDST_RT;
                state_d = S_WB;
            end
            S_MWR: begin
                mem_wr  = 1'b1;
                state_d = term_next;
            end
            S_WB: begin
                reg_wr  = 1'b1;
                reg_dst = (cls[CLS_ADDU] | cls[CLS_SUBU]) ? REGDST_RD : REGDST_RT;
                wd_sel  = cls[CLS_LW] ? WD_MEM : WD_ALU;
                state_d = term_next;
            end
            S_BR: begin
                // PC already points at beq + 4, which the branch offset is relative to
                alu_op  = ALU_SUB;
                pc_wr   = bus.Zero;
                npc_sel = NPC_BEQ_JMP;
                state_d = term_next;
            end
            S_JMP: begin
                pc_wr = 1'b1;
                if (cls[CLS_J] | cls[CLS_JAL]) begin
                    npc_sel = NPC_J_JMP;
                    if (cls[CLS_JAL]) begin
                        // Link value is the PC before this write: jal + 4
                        reg_wr  = 1'b1;
                        reg_dst = REGDST_31;
                        wd_sel  = WD_PC;
                    end
                end else begin
                    npc_sel = NPC_REG_JMP;
`ifdef CTRL_INT_EN
                    if (cls[CLS_ERET]) begin
                        epc_to_pc = 1'b1;
                        exl_clr   = 1'b1;
                    end
`endif
                end
                state_d = term_next;
            end
`ifdef CTRL_INT_EN
            S_INT: begin
                // PC holds the next unexecuted instruction; save it as EPC
                epc_wr  = 1'b1;
                exl_set = 1'b1;
                pc_wr   = 1'b1;
                npc_sel = NPC_INT_JMP;
                state_d = S_FETCH;
            end
`endif
            default: state_d = S_FETCH;
        endcase
    end

    // PC/IR strobes are held off while reset is asserted so the PC cannot step
    assign bus.IRWr   = ir_wr & ~reset;
    assign bus.PCWr   = pc_wr & ~reset;
    assign bus.NPCSel = npc_sel;
    assign bus.RegWr  = reg_wr;
    assign bus.RegDst = reg_dst;
    assign bus.WDSel  = wd_sel;
    assign bus.ALUSrc = alu_src;
    assign bus.ALUOp  = alu_op;
    assign bus.ExtOp  = ext_op;
    assign bus.MemWr  = mem_wr;
`ifdef CTRL_INT_EN
    assign bus.EPCWr   = epc_wr;
    assign bus.EXLSet  = exl_set;
    assign bus.EXLClr  = exl_clr;
    assign bus.EPCToPC = epc_to_pc;
`endif
endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl. Builds with or without CTRL_INT_EN.
module tb_mc_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    mc_ctrl_if bus();

    mc_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // {IRWr, PCWr, NPCSel, RegWr, RegDst, WDSel, ALUSrc, ALUOp, ExtOp, MemWr}
    logic [16:0] outs;
    assign outs = {bus.IRWr, bus.PCWr, bus.NPCSel, bus.RegWr, bus.RegDst,
                   bus.WDSel, bus.ALUSrc, bus.ALUOp, bus.ExtOp, bus.MemWr};

    function automatic logic [16:0] ov(input logic irwr, input logic pcwr,
                                       input logic [2:0] npc, input logic regwr,
                                       input logic [1:0] rdst, input logic [1:0] wd,
                                       input logic asrc, input logic [2:0] aop,
                                       input logic [1:0] ext, input logic memwr);
        return {irwr, pcwr, npc, regwr, rdst, wd, asrc, aop, ext, memwr};
    endfunction

    task automatic chk(input string tag, input logic [16:0] exp);
        checks++;
        assert (outs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, outs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [16:0] O_IDLE  = 17'd0;
    logic [16:0] o_fetch;

    initial begin
        o_fetch = ov(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        bus.instruction = 32'h8C080004;   // lw $t0, 4($zero)
        bus.Zero = 1'b0;
`ifdef CTRL_INT_EN
        bus.IntReq = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #2;
        chk("reset_outputs", O_IDLE);

        // lw: FETCH DECODE ADR MRD WB, FETCH again on cycle 6
        reset = 1'b0;
        #1;
        chk("lw_fetch", o_fetch);
        tick(); chk("lw_decode", O_IDLE);
        tick(); chk("lw_adr", ov(0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
        tick(); chk1("lw_mrd_regwr", bus.RegWr, 1'b0);
                chk1("lw_mrd_memwr", bus.MemWr, 1'b0);
        tick(); chk("lw_wb", ov(0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
        tick(); chk("lw_refetch", o_fetch);

        // beq: Zero=1 takes the branch, Zero=0 holds the PC
        bus.instruction = 32'h1000FFFF;
        tick(); chk("beq_decode", O_IDLE);
        bus.Zero = 1'b1;
        tick(); #1; chk("beq_taken", ov(0, 1, 3, 0, 0, 0, 0, 1, 0, 0));
        bus.Zero = 1'b0;
        #1;     chk("beq_not_taken", ov(0, 0, 3, 0, 0, 0, 0, 1, 0, 0));
        tick(); chk("beq_refetch", o_fetch);

        // jal
        bus.instruction = 32'h0C000010;
        tick(); chk("jal_decode", O_IDLE);
        tick(); chk("jal_jmp", ov(0, 1, 2, 1, 2, 2, 0, 0, 0, 0));
        tick(); chk("jal_refetch", o_fetch);

        // Unknown opcode: FETCH, DECODE, FETCH with no strobes
        bus.instruction = 32'hFC000000;
        tick(); chk("nop_decode", O_IDLE);
        tick(); chk("nop_refetch", o_fetch);

        // sw
        bus.instruction = 32'hAC080004;
        tick(); chk("sw_decode", O_IDLE);
        tick(); chk("sw_adr", ov(0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
        tick(); chk("sw_mwr", ov(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        tick(); chk("sw_refetch", o_fetch);

        // ori; live instruction changes after FETCH must not affect decode
        bus.instruction = 32'h3508FFFF;
        tick(); chk("ori_decode", O_IDLE);
        bus.instruction = 32'h0C000010;
        tick(); chk("ori_exe", ov(0, 0, 0, 0, 0, 0, 1, 2, 0, 0));
        tick(); chk("ori_wb", ov(0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        tick(); chk("ori_refetch", o_fetch);

        // subu: EXE uses sub, WB to rd
        bus.instruction = 32'h01095023;
        tick(); tick(); chk("subu_exe", ov(0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        tick(); chk("subu_wb", ov(0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
        tick(); chk("subu_refetch", o_fetch);

        // lui
        bus.instruction = 32'h3C081234;
        tick(); tick(); chk("lui_exe", ov(0, 0, 0, 0, 0, 0, 1, 3, 1, 0));
        tick(); tick(); chk("lui_refetch", o_fetch);

        // jr
        bus.instruction = 32'h01000008;
        tick(); tick(); chk("jr_jmp", ov(0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        tick(); chk("jr_refetch", o_fetch);

`ifdef CTRL_INT_EN
        // eret: JMP via EPC, clears EXL
        bus.instruction = 32'h42000018;
        tick(); tick(); chk("eret_jmp", ov(0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        chk1("eret_epctopc", bus.EPCToPC, 1'b1);
        chk1("eret_exlclr", bus.EXLClr, 1'b1);
        tick(); chk("eret_refetch", o_fetch);

        // addu with IntReq raised in EXE: WB completes, then INT, then FETCH
        bus.instruction = 32'h01095021;
        tick(); tick(); chk("int_addu_exe", ov(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        bus.IntReq = 1'b1;
        tick(); chk("int_addu_wb", ov(0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
        tick(); chk("int_state", ov(0, 1, 4, 0, 0, 0, 0, 0, 0, 0));
        chk1("int_epcwr", bus.EPCWr, 1'b1);
        chk1("int_exlset", bus.EXLSet, 1'b1);
        bus.IntReq = 1'b0;
        tick(); chk("int_refetch", o_fetch);
        chk1("int_epcwr_clear", bus.EPCWr, 1'b0);
`else
        // Without interrupt support eret is a NOP
        bus.instruction = 32'h42000018;
        tick(); chk("eret_nop_decode", O_IDLE);
        tick(); chk("eret_nop_refetch", o_fetch);

        // addu: EXE add with sign extend, WB to rd
        bus.instruction = 32'h01095021;
        tick(); tick(); chk("addu_exe", ov(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        tick(); chk("addu_wb", ov(0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
        tick(); chk("addu_refetch", o_fetch);
`endif

        // Reset pulsed in MRD of a lw: immediate FETCH, no write strobes
        bus.instruction = 32'h8C080004;
        tick(); tick(); tick();
        chk1("rst_pre_mrd_regwr", bus.RegWr, 1'b0);
        reset = 1'b1;
        #1;     chk("rst_in_mrd", O_IDLE);
        tick(); chk("rst_held", O_IDLE);
        bus.instruction = 32'hFC000000;
        #2;
        reset = 1'b0;
        #1;     chk("rst_release_fetch", o_fetch);
        tick(); chk1("rst_after_regwr", bus.RegWr, 1'b0);
                chk1("rst_after_memwr", bus.MemWr, 1'b0);
        tick(); chk("rst_after_refetch", o_fetch);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog: the directed sequence is short
    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end
endmodule
